ysyx_201979054_div_unit: RTL and testbench

Multi-cycle iterative divider that consumes the 5-bit ALU control code from the ALU decoder in the execute stage. It handles the divide/remainder codes: DIVU, REMU, DIVW, DIVUW, REMW and REMUW. A radix-2 restoring algorithm produces one quotient bit per cycle. A start/busy/done handshake lets the main-control FSM stall the core until the result is ready.

---
 rtl/ysyx_201979054_pkg.sv | 18 +
 rtl/ysyx_201979054_div_step.sv | 26 ++
 rtl/ysyx_201979054_div_unit.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_201979054_div_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_201979054_pkg.sv
// Shared ALU control codes and divider state encoding.
// Imported by the ALU decoder and the iterative divider.
package ysyx_201979054_pkg;

    localparam logic [4:0] ALU_DIVW  = 5'b10011;
    localparam logic [4:0] ALU_DIVU  = 5'b10101;
    localparam logic [4:0] ALU_DIVUW = 5'b10110;
    localparam logic [4:0] ALU_REMU  = 5'b10111;
    localparam logic [4:0] ALU_REMUW = 5'b11000;
    localparam logic [4:0] ALU_REMW  = 5'b11001;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } t_div_state;

endpackage

// File: rtl/ysyx_201979054_div_step.sv
// One radix-2 restoring division iteration.
// Shifts {rem, quo} left and keeps the trial difference on no-borrow.
module ysyx_201979054_div_step
    import ysyx_201979054_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Trial subtract; the extra top bit is the borrow.
    always_comb begin
        shifted = {i_rem, i_quo[XLEN-1]};
        diff    = shifted - {1'b0, i_div};
        o_quo   = {i_quo[XLEN-2:0], ~diff[XLEN]};
        o_rem   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end

endmodule

// File: rtl/ysyx_201979054_div_unit.sv
// Multi-cycle restoring divider for the DIV/REM family.
// Start/busy/done handshake lets the control FSM stall the core.
module ysyx_201979054_div_unit
    import ysyx_201979054_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [4:0]      i_alu_control,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int HW = XLEN - 32;

    t_div_state state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] pr_q, pr_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            w_q, w_d;
    logic            is_rem_q, is_rem_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;

    logic            in_ok, in_w, in_rem, in_sgn;
    logic [31:0]     a32, b32, a_abs, b_abs;
    logic            a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] pr_nx, quo_nx;
    logic [XLEN-1:0] raw, val, fix_res;
    logic            neg;

    // Decode the incoming opcode into width/kind/signedness.
    always_comb begin
        in_ok  = 1'b1;
        in_w   = 1'b0;
        in_rem = 1'b0;
        in_sgn = 1'b0;
        case (i_alu_control)
            ALU_DIVU:  ;
            ALU_REMU:  in_rem = 1'b1;
            ALU_DIVUW: in_w = 1'b1;
            ALU_REMUW: begin in_w = 1'b1; in_rem = 1'b1; end
            ALU_DIVW:  begin in_w = 1'b1; in_sgn = 1'b1; end
            ALU_REMW:  begin
                in_w   = 1'b1;
                in_rem = 1'b1;
                in_sgn = 1'b1;
            end
            default:   in_ok = 1'b0;
        endcase
    end

    // Operand conditioning and the results that bypass iteration.
    always_comb begin
        a32      = i_src_a[31:0];
        b32      = i_src_b[31:0];
        a_neg    = in_sgn & a32[31];
        b_neg    = in_sgn & b32[31];
        a_abs    = a_neg ? -a32 : a32;
        b_abs    = b_neg ? -b32 : b32;
        div_zero = in_w ? (b32 == '0) : (i_src_b == '0);
        ovf      = in_sgn && (a32 == 32'h8000_0000)
                   && (b32 == 32'hFFFF_FFFF);
        special_res = '0;
        if (div_zero) begin
            if (!in_rem)
                special_res = '1;
            else if (in_w)
                special_res = {{HW{a32[31]}}, a32};
            else
                special_res = i_src_a;
        end else if (!in_rem) begin
            special_res = {{HW{1'b1}}, 32'h8000_0000};
        end
    end

    ysyx_201979054_div_step #(.XLEN(XLEN)) u_step (
        .i_rem (pr_q),
        .i_quo (quo_q),
        .i_div (dvs_q),
        .o_rem (pr_nx),
        .o_quo (quo_nx)
    );

    // Sign fix-up and W sign extension of the final iteration.
    always_comb begin
        raw = is_rem_q ? pr_nx : quo_nx;
        if (w_q)
            raw = {{HW{1'b0}}, raw[31:0]};
        neg     = is_rem_q ? rneg_q : qneg_q;
        val     = neg ? -raw : raw;
        fix_res = w_q ? {{HW{val[31]}}, val[31:0]} : val;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pr_d     = pr_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        res_d    = res_q;
        w_d      = w_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        unique case (state_q)
            IDLE: begin
                if (i_start && in_ok) begin
                    w_d      = in_w;
                    is_rem_d = in_rem;
                    qneg_d   = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    pr_d     = '0;
                    quo_d    = in_w ? {a_abs, {HW{1'b0}}} : i_src_a;
                    dvs_d    = in_w ? {{HW{1'b0}}, b_abs} : i_src_b;
                    cnt_d    = in_w ? CW'(32) : CW'(XLEN);
                    if (div_zero || ovf) begin
                        res_d   = special_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                pr_d  = pr_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = fix_res;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pr_q     <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            w_q      <= 1'b0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pr_q     <= pr_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
            w_q      <= w_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign o_busy   = (state_q != IDLE);
    assign o_done   = (state_q == DONE);
    assign o_result = res_q;

endmodule

// File: tb/tb_ysyx_201979054_div_unit.sv
// Scoreboard bench for the iterative divider.
// Reference model uses plain arithmetic on the operands.
module tb_ysyx_201979054_div_unit;
    import ysyx_201979054_pkg::*;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_flush = 1'b0;
    logic [4:0]  i_alu_control = '0;
    logic [63:0] i_src_a = '0;
    logic [63:0] i_src_b = '0;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_result;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    logic [63:0] last_exp = '0;
    logic [4:0]  ops [6];

    ysyx_201979054_div_unit #(.XLEN(64)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_flush       (i_flush),
        .i_alu_control (i_alu_control),
        .i_src_a       (i_src_a),
        .i_src_b       (i_src_b),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [4:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [31:0] a32, b32;
        int sa, sb;
        logic ov;
        a32 = a[31:0];
        b32 = b[31:0];
        sa = $signed(a32);
        sb = $signed(b32);
        ov = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
        case (op)
            ALU_DIVU:  return (b == 0) ? '1 : a / b;
            ALU_REMU:  return (b == 0) ? a : a % b;
            ALU_DIVUW: return (b32 == 0) ? '1 : sx(a32 / b32);
            ALU_REMUW: return (b32 == 0) ? sx(a32) : sx(a32 % b32);
            ALU_DIVW: begin
                if (b32 == 0) return '1;
                if (ov) return sx(32'h8000_0000);
                return sx(32'(sa / sb));
            end
            ALU_REMW: begin
                if (b32 == 0) return sx(a32);
                if (ov) return '0;
                return sx(32'(sa % sb));
            end
            default: return '0;
        endcase
    endfunction

    function automatic int latency(input logic [4:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        logic w, s;
        w = (op != ALU_DIVU) && (op != ALU_REMU);
        s = (op == ALU_DIVW) || (op == ALU_REMW);
        if (w ? (b[31:0] == 0) : (b == 0)) return 1;
        if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
            return 1;
        return w ? 33 : 65;
    endfunction

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge i_clk) begin
        if (!i_rst && o_done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cyc=%0d result=%h", cyc, o_result);
            end else begin
                exp_t e;
                e = q.pop_front();
                last_exp = e.res;
                checks++;
                if (o_result !== e.res) begin
                    failures++;
                    $display("FAIL result got=%h exp=%h", o_result, e.res);
                end
                checks++;
                if (cyc != e.due) begin
                    failures++;
                    $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic issue_exp(input logic [4:0] op, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] r,
                             input int lat);
        exp_t e;
        i_start = 1'b1;
        i_alu_control = op;
        i_src_a = a;
        i_src_b = b;
        e.res = r;
        e.due = cyc + lat;
        q.push_back(e);
        step();
        i_start = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b);
        issue_exp(op, a, b, model(op, a, b), latency(op, a, b));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout pending=%0d exp=%0d", q.size(), 0);
            q.delete();
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        logic [4:0] op;
        int k;
        ops = '{ALU_DIVU, ALU_REMU, ALU_DIVUW,
                ALU_REMUW, ALU_DIVW, ALU_REMW};
        step();
        step();
        i_rst = 1'b0;
        step();
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_done", 64'(o_done), 64'd0);
        check("reset_result", o_result, 64'd0);

        issue_exp(ALU_DIVU, 64'd100, 64'd7, 64'd14, 65);
        check("busy_after_accept", 64'(o_busy), 64'd1);
        wait_idle();
        issue_exp(ALU_REMU, 64'd100, 64'd7, 64'd2, 65);
        wait_idle();
        issue_exp(ALU_DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFD, 33);
        wait_idle();
        issue_exp(ALU_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFF, 33);
        wait_idle();
        issue_exp(ALU_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        wait_idle();
        issue_exp(ALU_REMUW, 64'h1_0000_0005, 64'h2_0000_0000, 64'd5, 1);
        wait_idle();
        issue_exp(ALU_DIVW, 64'h8000_0000, 64'hFFFF_FFFF,
                  64'hFFFF_FFFF_8000_0000, 1);
        wait_idle();
        issue_exp(ALU_REMW, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
        wait_idle();

        // flush at T+10, restart at T+12
        k = cyc;
        issue(ALU_DIVU, 64'd123456789, 64'd1000);
        while (cyc < k + 10) step();
        i_flush = 1'b1;
        void'(q.pop_back());
        step();
        i_flush = 1'b0;
        check("flush_busy", 64'(o_busy), 64'd0);
        check("flush_result_held", o_result, last_exp);
        step();
        k = cyc;
        issue(ALU_DIVU, 64'hDEAD_BEEF_1234_5678, 64'd12345);
        wait_idle();

        // reset at T+10, restart at T+12
        k = cyc;
        issue(ALU_REMU, 64'd987654321, 64'd77);
        while (cyc < k + 10) step();
        i_rst = 1'b1;
        void'(q.pop_back());
        step();
        i_rst = 1'b0;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_result", o_result, 64'd0);
        step();
        issue(ALU_REMU, 64'hFFFF_0000_FFFF_0000, 64'd999);
        wait_idle();

        // second start during busy is ignored
        k = cyc;
        issue(ALU_DIVU, 64'd1_000_000, 64'd3);
        while (cyc < k + 5) step();
        i_start = 1'b1;
        i_alu_control = ALU_DIVUW;
        i_src_a = 64'd50;
        i_src_b = 64'd0;
        step();
        i_start = 1'b0;
        wait_idle();

        // unsupported code leaves the unit idle
        i_start = 1'b1;
        i_alu_control = 5'b00000;
        step();
        i_start = 1'b0;
        check("bad_op_busy", 64'(o_busy), 64'd0);
        step();
        step();
        check("bad_op_busy_later", 64'(o_busy), 64'd0);

        // flush beats start in IDLE
        i_start = 1'b1;
        i_flush = 1'b1;
        i_alu_control = ALU_DIVU;
        i_src_a = 64'd9;
        i_src_b = 64'd0;
        step();
        i_start = 1'b0;
        i_flush = 1'b0;
        check("flush_start_busy", 64'(o_busy), 64'd0);
        step();
        step();

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 5)];
            a = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = 64'h8000_0000;
            if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
            case ($urandom_range(0, 4))
                0: b = 64'd0;
                1: b = 64'($urandom_range(1, 20));
                2: b = {$urandom, $urandom};
                3: b = '1;
                default: b = 64'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) b = -b;
            issue(op, a, b);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
